count_seg7_display: RTL
=======================

Name: count_seg7_display

Overview:
- Downstream consumer of the 8-bit free-running count produced by the one-second counter stage.
- Converts the binary count to 3-digit BCD using a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the result onto a 4-digit common-anode 7-segment display.
- Sits between the counter's 8-bit output and the board's segment/anode pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays lit (legal range 2 to 2^24-1).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk only.
- cin  input  8  binary count from the counter stage, unsigned 0-255.
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low, registered.
- an  output  4  digit anodes, active-low one-hot (an[0] is the ones digit), registered.
- dp  output  1  decimal point, active-low; always 1 (off).
- bcd  output  12  {hundreds,tens,ones} of last completed conversion, registered.
- busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset values: seg=7'b1111111, an=4'b1111, dp=1, bcd=12'h000, busy=0, last_val=0, refresh counter=0, digit index=0, FSM=IDLE.
- FSM states IDLE, CONVERT, DONE.
- IDLE: each cycle compares cin with last_val. On mismatch at cycle T:
  - capture cin into the shift register and into last_val;
  - clear the BCD scratch register;
  - go to CONVERT. busy=1 from T+1.
- CONVERT: exactly 8 cycles (T+1..T+8). Each cycle:
  - add 3 to every scratch nibble >= 5;
  - then shift {scratch, shift} left by 1.
  - A 3-bit iteration counter sets the cycle count.
- DONE (T+9): bcd <= scratch; busy <= 0; return to IDLE.
  - The new bcd value is visible at T+10.
  - IDLE can detect the next change at T+10 at the earliest.
- cin changes during CONVERT/DONE are ignored. The latest cin is compared when the FSM is back in IDLE, so no update is lost, only delayed.
- Arithmetic: scratch is 12 bits; the max input 255 yields 12'h255. No overflow is possible.
- Refresh counter: counts 0..REFRESH_DIV-1. On reaching REFRESH_DIV-1 it wraps to 0 and the digit index advances 0->1->2->3->0 (2-bit wrap).
- Display mapping (an and seg update in the same cycle, one cycle after the index change):
  - index 0: an=1110, seg=ones;
  - index 1: an=1101, seg=tens;
  - index 2: an=1011, seg=hundreds;
  - index 3: an=0111, seg=1111111 (blank).
- Display always reads the registered bcd, never the scratch register, so no partial values are ever shown.
- Segment codes, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001;
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any other nibble value: 1111111.
- Reset mid-conversion aborts it: FSM to IDLE, bcd=0, last_val=0. If cin is nonzero, a fresh conversion starts on the first cycle after reset deasserts.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - hundreds digit is blank (1111111) when hundreds==0;
  - tens digit is blank when hundreds==0 and tens==0;
  - ones digit is always shown.
- Undefined: all three digits are always shown, including leading zeros (e.g. 007).
- Anode scanning is identical in both builds.

Test Plan:
- Reset, REFRESH_DIV=4, cin=0 -> bcd=000, busy never rises; an cycles 1110,1101,1011,0111 every 4 clks; seg=1000000 on indices 0-2.
- cin 0->255 at cycle T -> busy=1 for T+1..T+9, bcd=12'h255 at T+10; index 0 shows seg=0010010 (5), index 2 shows seg=0100100 (2).
- cin=100 then cin=99 applied at T+3 (mid-convert) -> bcd=100 at T+10, second conversion detected at T+10, bcd=099 at T+20.
- Reset asserted at T+4 of a conversion of 200 -> bcd=000, busy=0 next cycle; cin still 200 after release -> bcd=200 ten cycles after first post-reset cycle.
- cin=7 with SEG7_LEADING_ZERO_BLANK_EN defined -> hundreds and tens seg=1111111, ones seg=1111000; undefined -> hundreds and tens seg=1000000.
- Sweep cin 0..255 with wait for busy low each step -> bcd equals decimal of cin for all 256 values.

Source files
------------

// File: rtl/count_seg7_display.sv
// Binary-to-BCD (shift-add-3) converter driving a multiplexed 4-digit common-anode 7-segment display.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading-zero hundreds/tens digits.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | watch cin against last_val, start a conversion on change
// CONVERT | 8 add-3/shift iterations on {scratch, shift}
// DONE    | publish scratch to bcd, drop busy, return to IDLE

module count_seg7_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  cin,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic [11:0] bcd,
    output logic        busy
);

    localparam logic [23:0] RC_LAST = 24'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  last_val;
    logic [7:0]  shift;
    logic [11:0] scratch;
    logic [11:0] scratch_adj;
    logic [2:0]  iter;
    logic [23:0] refresh_cnt;
    logic [1:0]  digit_idx;
    logic [6:0]  seg_next;
    logic [3:0]  an_next;
    logic        blank_hund;
    logic        blank_tens;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = 7'b1111111;
        endcase
        return code;
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cin != last_val) state_next = CONVERT;
            CONVERT: if (iter == 3'd7)    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        scratch_adj = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
    end

    // Conversion datapath; bcd only changes in DONE so the display never sees partial sums
    always_ff @(posedge clk) begin
        if (reset) begin
            last_val <= 8'd0;
            shift    <= 8'd0;
            scratch  <= 12'd0;
            iter     <= 3'd0;
            bcd      <= 12'd0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cin != last_val) begin
                        shift    <= cin;
                        last_val <= cin;
                        scratch  <= 12'd0;
                        iter     <= 3'd0;
                        busy     <= 1'b1;
                    end
                end
                CONVERT: begin
                    scratch <= {scratch_adj[10:0], shift[7]};
                    shift   <= {shift[6:0], 1'b0};
                    iter    <= iter + 3'd1;
                end
                DONE: begin
                    bcd  <= scratch;
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= 24'd0;
            digit_idx   <= 2'd0;
        end else if (refresh_cnt == RC_LAST) begin
            refresh_cnt <= 24'd0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 24'd1;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign blank_hund = (bcd[11:8] == 4'd0);
    assign blank_tens = blank_hund && (bcd[7:4] == 4'd0);
`else
    assign blank_hund = 1'b0;
    assign blank_tens = 1'b0;
`endif

    always_comb begin
        an_next  = 4'b1111;
        seg_next = 7'b1111111;
        case (digit_idx)
            2'd0: begin
                an_next  = 4'b1110;
                seg_next = seg_code(bcd[3:0]);
            end
            2'd1: begin
                an_next  = 4'b1101;
                seg_next = blank_tens ? 7'b1111111 : seg_code(bcd[7:4]);
            end
            2'd2: begin
                an_next  = 4'b1011;
                seg_next = blank_hund ? 7'b1111111 : seg_code(bcd[11:8]);
            end
            default: begin
                an_next  = 4'b0111;
                seg_next = 7'b1111111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= 7'b1111111;
            an  <= 4'b1111;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

    assign dp = 1'b1;

endmodule
